// File: rtl/inv_mix_columns_seq.sv
// Purpose: iterative AES InvMixColumns, transforming COLS_PER_CYCLE columns per clock in place.
// Latency: out_valid rises in the cycle after edge T + 4/COLS_PER_CYCLE, where T is the input handshake edge.
// Backpressure: one state in flight; the result is held in DONE until out_ready, and in_ready stays low until then.
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data
);

  // Only 1, 2 and 4 columns per clock divide the four-column state evenly.
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Column index advance per BUSY cycle (4 wraps to 0 in two bits).
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  // First column of the final BUSY cycle; the step that covers column 3 starts here.
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [0:127] r_state;
  logic [1:0]   r_col;
  logic [3:0]   w_sel;
  logic [31:0]  w_col_res [4];
  logic         w_busy_last;

  // GF(2^8) multiply-by-x with reduction by 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One InvMixColumns column; a[31:24] is row 0.
  function automatic logic [31:0] inv_col(input logic [31:0] a);
    logic [7:0] ab [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] b0, b1, b2, b3;
    for (int i = 0; i < 4; i++) begin
      ab[i] = a[31-8*i -: 8];
      x2[i] = xtime(ab[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ ab[i];
      mb[i] = x8[i] ^ x2[i] ^ ab[i];
      md[i] = x8[i] ^ x4[i] ^ ab[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    b0 = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    b1 = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    b2 = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    b3 = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    return {b0, b1, b2, b3};
  endfunction

  // A column is in this cycle's window when its distance past r_col is below the step size.
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [1:0] w_off;
    assign w_off        = 2'(c) - r_col;
    assign w_sel[c]     = ({30'd0, w_off} < 32'(COLS_PER_CYCLE));
    assign w_col_res[c] = inv_col(r_state[32*c +: 32]);
  end

  assign w_busy_last = (r_col == LAST_COL);
  assign out_data    = r_state;

  // State register; reset wins over any simultaneous handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_fsm_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_busy_last) begin
          w_fsm_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_fsm_nxt = S_IDLE;
        end
      end
      default: begin
        w_fsm_nxt = S_IDLE;
      end
    endcase
  end

  // Working register: capture on accept, rewrite the selected columns while BUSY, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= '0;
      r_col   <= '0;
    end else if (r_fsm == S_IDLE && in_valid) begin
      r_state <= in_data;
      r_col   <= '0;
    end else if (r_fsm == S_BUSY) begin
      for (int c = 0; c < 4; c++) begin
        if (w_sel[c]) begin
          r_state[32*c +: 32] <= w_col_res[c];
        end
      end
      r_col <= r_col + COL_STEP;
    end
  end

endmodule
